// File: rtl/fnd_scan_ctrl_pkg.sv
// fnd_scan_ctrl_pkg: shared 7-segment glyph constants and idle levels for the FND scan controller.
//   Glyphs are active-low seg_n bytes with the decimal point off: [6:0] = g..a, [7] = dp.
//   SEG_OFF / COM_OFF are the all-dark segment and common levels.
package fnd_scan_ctrl_pkg;
    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] COM_OFF = 4'hF;
endpackage

// File: rtl/fnd_scan_ctrl_seg7_decoder.sv
// fnd_scan_ctrl_seg7_decoder: combinational nibble to active-low 7-segment pattern (0-9, A b C d E F).
//   nib    in  4  hex digit
//   seg_n  out 7  active-low segments g..a
module fnd_scan_ctrl_seg7_decoder
    import fnd_scan_ctrl_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);
    always_comb begin
        seg_n = SEG_OFF[6:0];
        case (nib)
            4'h0: seg_n = SEG_0[6:0];
            4'h1: seg_n = SEG_1[6:0];
            4'h2: seg_n = SEG_2[6:0];
            4'h3: seg_n = SEG_3[6:0];
            4'h4: seg_n = SEG_4[6:0];
            4'h5: seg_n = SEG_5[6:0];
            4'h6: seg_n = SEG_6[6:0];
            4'h7: seg_n = SEG_7[6:0];
            4'h8: seg_n = SEG_8[6:0];
            4'h9: seg_n = SEG_9[6:0];
            4'hA: seg_n = SEG_A[6:0];
            4'hB: seg_n = SEG_B[6:0];
            4'hC: seg_n = SEG_C[6:0];
            4'hD: seg_n = SEG_D[6:0];
            4'hE: seg_n = SEG_E[6:0];
            default: seg_n = SEG_F[6:0];
        endcase
    end
endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit common-anode FND scanner with per-frame latching and inter-digit blanking.
//   clk         in   1   system clock
//   reset_n     in   1   asynchronous reset, active low
//   value       in   16  four nibbles, [3:0] = digit0 (rightmost)
//   dp_in       in   4   decimal point request per digit, 1 = on
//   blink_mask  in   4   per-digit blink enable (only when FND_BLINK_EN is defined)
//   seg_n       out  8   active-low segments, [6:0] = g..a, [7] = dp
//   com_n       out  4   active-low digit commons, [0] = digit0
// Optional feature macro: FND_BLINK_EN (adds blink_mask, BLINK_DIV and the blink counter).
module fnd_scan_ctrl
    import fnd_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLANK_CYC = 100
`ifdef FND_BLINK_EN
    ,
    parameter int BLINK_DIV = 50_000_000
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
`ifdef FND_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic [7:0]  seg_n,
    output logic [3:0]  com_n
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK     = SW'(BLANK_CYC);
    logic [SW-1:0] slot_cnt;
    logic [1:0]    idx;
    logic [15:0]   frame;
    logic [3:0]    dp_frame;
    logic          load_pend;
    logic [6:0]    glyph;
    logic          blink_dark;
    logic          dark;
    logic [3:0]    com_d;
    logic [7:0]    seg_d;
    fnd_scan_ctrl_seg7_decoder u_dec (
        .nib   (frame[idx*4 +: 4]),
        .seg_n (glyph)
    );
`ifdef FND_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
            if (blink_cnt == BLINK_LAST) blink_ph <= ~blink_ph;
        end
    end
    // Mask is taken live so a blink request takes effect without waiting for a frame.
    assign blink_dark = blink_ph & blink_mask[idx];
`else
    assign blink_dark = 1'b0;
`endif
    // The load_pend edge only captures the first frame, so its output is forced dark
    // and the slot timer starts one edge later.
    always_comb begin
        dark  = load_pend | (slot_cnt < BLANK) | blink_dark;
        com_d = dark ? COM_OFF : ~(4'b0001 << idx);
        seg_d = dark ? SEG_OFF : {~dp_frame[idx], glyph};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt  <= '0;
            idx       <= 2'd0;
            frame     <= 16'h0000;
            dp_frame  <= 4'h0;
            load_pend <= 1'b1;
            com_n     <= COM_OFF;
            seg_n     <= SEG_OFF;
        end else begin
            load_pend <= 1'b0;
            if (load_pend || (slot_cnt == SLOT_LAST && idx == 2'd3)) begin
                frame    <= value;
                dp_frame <= dp_in;
            end
            if (!load_pend) begin
                slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
                if (slot_cnt == SLOT_LAST) idx <= idx + 1'b1;
            end
            com_n <= com_d;
            seg_n <= seg_d;
        end
    end
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: randomized and directed checks of fnd_scan_ctrl against an edge-count reference model.
module tb_fnd_scan_ctrl;
    localparam int SD = 10;
    localparam int BK = 2;
    localparam int BD = 40;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic [7:0]  seg_n;
    logic [3:0]  com_n;
    int          compared = 0;
    int          mismatched = 0;
    int          e = 0;
    logic [15:0] m_frame = 16'h0000;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  exp_com = 4'hF;
    logic [7:0]  exp_seg = 8'hFF;
    logic [7:0]  glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    always #5 clk = ~clk;
    fnd_scan_ctrl #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BK)
`ifdef FND_BLINK_EN
        ,
        .BLINK_DIV (BD)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .dp_in      (dp_in),
`ifdef FND_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg_n      (seg_n),
        .com_n      (com_n)
    );
    // Reference: e counts edges since reset release. Edge 1 captures the first frame;
    // from edge 2 the display walks a 4*SD-cycle frame whose position is p = e-2.
    // A new frame is captured on every edge with (e-1) a multiple of 4*SD.
    always @(posedge clk or negedge reset_n) begin
        int   p;
        int   d;
        logic dk;
        if (!reset_n) begin
            e = 0;
            exp_com = 4'hF;
            exp_seg = 8'hFF;
        end else begin
            e++;
            p = e - 2;
            d = (p < 0) ? 0 : (p / SD) % 4;
            dk = (e < 2) || (p % SD) < BK;
`ifdef FND_BLINK_EN
            dk = dk || ((((e - 1) / BD) % 2 == 1) && blink_mask[d]);
`endif
            exp_com = dk ? 4'hF : ~(4'b0001 << d);
            exp_seg = dk ? 8'hFF : (glyph[m_frame[d*4 +: 4]] & (m_dp[d] ? 8'h7F : 8'hFF));
            if ((e - 1) % (4 * SD) == 0) begin
                m_frame = value;
                m_dp = dp_in;
            end
        end
    end
    task automatic test_reset();
        reset_n = 1'b0;
        value = 16'h1234;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (17) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        compared++;
        if (com_n !== 4'hF || seg_n !== 8'hFF) begin
            mismatched++;
            $display("FAIL reset_async: com_n=%b seg_n=%h expected com_n=1111 seg_n=ff", com_n, seg_n);
        end
        @(negedge clk);
        value = 16'h1234;
        dp_in = 4'h0;
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) value = 16'h5678;
            compared++;
            if (com_n !== exp_com || seg_n !== exp_seg) begin
                mismatched++;
                $display("FAIL reset_seq edge %0d: com_n=%b seg_n=%h expected com_n=%b seg_n=%h", k, com_n, seg_n, exp_com, exp_seg);
            end
            if (k < 4) begin
                compared++;
                if (com_n !== 4'hF) begin
                    mismatched++;
                    $display("FAIL reset_dark edge %0d: com_n=%b expected 1111", k, com_n);
                end
            end
            if (k == 4) begin
                compared++;
                if (com_n !== 4'b1110 || seg_n !== 8'h99) begin
                    mismatched++;
                    $display("FAIL first_lit: com_n=%b seg_n=%h expected com_n=1110 seg_n=99", com_n, seg_n);
                end
            end
        end
    endtask
    task automatic test_pattern();
        int lit = 0;
        value = 16'h1234;
        dp_in = 4'h0;
        for (int k = 0; k < 4 * SD && (e - 1) % (4 * SD) != 0; k++) @(negedge clk);
        for (int k = 0; k < 4 * SD; k++) begin
            @(negedge clk);
            if (com_n !== 4'hF) lit++;
            compared++;
            if (com_n !== exp_com || seg_n !== exp_seg || $countones(~com_n) > 1) begin
                mismatched++;
                $display("FAIL pattern: com_n=%b seg_n=%h expected com_n=%b seg_n=%h", com_n, seg_n, exp_com, exp_seg);
            end
            if (com_n == 4'b0111) begin
                compared++;
                if (seg_n !== 8'hF9) begin
                    mismatched++;
                    $display("FAIL pattern_digit3: seg_n=%h expected f9", seg_n);
                end
            end
        end
        compared++;
        if (lit != 4 * (SD - BK)) begin
            mismatched++;
            $display("FAIL pattern_lit_count: got %0d expected %0d", lit, 4 * (SD - BK));
        end
    endtask
    task automatic test_midframe();
        value = 16'h1234;
        for (int k = 0; k < 4 * SD && !((e - 2) % (4 * SD) == SD + 5); k++) @(negedge clk);
        value = 16'h5678;
        for (int k = 0; k < 4 * SD + 4; k++) begin
            @(negedge clk);
            compared++;
            if (com_n !== exp_com || seg_n !== exp_seg || $countones(~com_n) > 1) begin
                mismatched++;
                $display("FAIL midframe: com_n=%b seg_n=%h expected com_n=%b seg_n=%h", com_n, seg_n, exp_com, exp_seg);
            end
            if (com_n == 4'b1101 && k < 3 * SD) begin
                compared++;
                if (seg_n !== 8'hB0) begin
                    mismatched++;
                    $display("FAIL midframe_old_digit1: seg_n=%h expected b0", seg_n);
                end
            end
            if (com_n == 4'b1110) begin
                compared++;
                if (seg_n !== 8'h80) begin
                    mismatched++;
                    $display("FAIL midframe_new_digit0: seg_n=%h expected 80", seg_n);
                end
            end
        end
    endtask
    task automatic test_dp();
        dp_in = 4'b0100;
        repeat (8 * SD) @(negedge clk);
        for (int k = 0; k < 4 * SD; k++) begin
            @(negedge clk);
            if (k == SD + 3) dp_in = 4'b0000;
            compared++;
            if (seg_n[7] !== (com_n != 4'b1011) || seg_n !== exp_seg || com_n !== exp_com) begin
                mismatched++;
                $display("FAIL dp: com_n=%b seg_n=%h expected com_n=%b seg_n=%h", com_n, seg_n, exp_com, exp_seg);
            end
        end
    endtask
    task automatic test_hex();
        value = 16'hABCD;
        dp_in = 4'h0;
        for (int k = 0; k < 12 * SD; k++) begin
            @(negedge clk);
            compared++;
            if (com_n !== exp_com || seg_n !== exp_seg || $countones(~com_n) > 1) begin
                mismatched++;
                $display("FAIL hex: com_n=%b seg_n=%h expected com_n=%b seg_n=%h", com_n, seg_n, exp_com, exp_seg);
            end
            if (k >= 8 * SD && com_n == 4'b1110) begin
                compared++;
                if (seg_n !== 8'hA1) begin
                    mismatched++;
                    $display("FAIL hex_digit_d: seg_n=%h expected a1", seg_n);
                end
            end
        end
    endtask
    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            compared++;
            if (com_n !== exp_com || seg_n !== exp_seg || $countones(~com_n) > 1) begin
                mismatched++;
                $display("FAIL random cycle %0d: com_n=%b seg_n=%h expected com_n=%b seg_n=%h", k, com_n, seg_n, exp_com, exp_seg);
            end
            if ($urandom_range(0, 9) == 0) value = 16'($urandom);
            if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
`ifdef FND_BLINK_EN
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
`endif
        end
        blink_mask = 4'h0;
    endtask
`ifdef FND_BLINK_EN
    task automatic test_blink();
        int dark0 = 0;
        value = 16'h1234;
        blink_mask = 4'b0001;
        for (int k = 0; k < 4 * BD; k++) begin
            @(negedge clk);
            compared++;
            if (com_n !== exp_com || seg_n !== exp_seg) begin
                mismatched++;
                $display("FAIL blink: com_n=%b seg_n=%h expected com_n=%b seg_n=%h", com_n, seg_n, exp_com, exp_seg);
            end
            if (exp_com == 4'hF && ((e - 2) % SD) >= BK && ((e - 2) / SD) % 4 == 0) dark0++;
        end
        compared++;
        if (dark0 == 0) begin
            mismatched++;
            $display("FAIL blink_dark_slots: got %0d dark digit0 cycles expected > 0", dark0);
        end
        blink_mask = 4'b0000;
        for (int k = 0; k < 2 * BD; k++) begin
            @(negedge clk);
            compared++;
            if (com_n !== exp_com || seg_n !== exp_seg) begin
                mismatched++;
                $display("FAIL blink_off: com_n=%b seg_n=%h expected com_n=%b seg_n=%h", com_n, seg_n, exp_com, exp_seg);
            end
        end
    endtask
`endif
    initial begin
        test_reset();
        test_pattern();
        test_midframe();
        test_dp();
        test_hex();
`ifdef FND_BLINK_EN
        test_blink();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
